popcount_scheduler: RTL and testbench

//   Shares one registered 8-bit popcount (ones-count) datapath among NREQ

---
 rtl/popcount_scheduler.sv | 114 +++++++++++
 tb/tb_popcount_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_scheduler.sv
// popcount_scheduler: one shared registered popcount datapath serving NREQ
// requesters through a round-robin arbiter. Each job runs
// IDLE (grant and capture) -> COUNT (compute) -> RESP (hold until accepted).
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   req          per-requester request, held until its ack
//   req_data     packed operands; requester i owns [i*DW +: DW]
//   ack          one-hot single-cycle capture acknowledge
//   res_valid    result available; res_ready is the consumer accept
//   res_count    number of set bits in the captured operand
//   res_id       requester that owns res_count
//   busy         high whenever the FSM is not idle
module popcount_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned CW   = $clog2(DW + 1),
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     ack,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CW-1:0]       res_count,
  output logic [IDW-1:0]      res_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   operand;
  logic [IDW-1:0]  last_grant;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  int unsigned     cand;
  logic [CW-1:0]   ones;

  // Round-robin pick: first pending request starting just after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (32'(last_grant) + 32'd1 + k) % NREQ;
      if (!grant_found && req[IDW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
  end

  // Ones count over the captured operand; CW is wide enough to hold DW.
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      ones = ones + CW'(operand[i]);
    end
  end

  // Sequencer with registered outputs; pointer resets so requester 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ack        <= '0;
      res_valid  <= 1'b0;
      res_count  <= '0;
      res_id     <= '0;
      busy       <= 1'b0;
      operand    <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            operand    <= req_data[32'(grant_idx) * DW +: DW];
            res_id     <= grant_idx;
            ack        <= NREQ'(1) << grant_idx;
            last_grant <= grant_idx;
            busy       <= 1'b1;
            state      <= COUNT;
          end
        end
        COUNT: begin
          res_count <= ones;
          res_valid <= 1'b1;
          ack       <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          ack       <= '0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_scheduler.sv
// Self-checking bench for popcount_scheduler: directed vector table plus
// hand-written sequences for reset, round-robin order, backpressure and
// dropped requests.
module tb_popcount_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned IDW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     ack;
  logic                res_valid;
  logic                res_ready;
  logic [CW-1:0]       res_count;
  logic [IDW-1:0]      res_id;
  logic                busy;

  int passed = 0;
  int total  = 0;

  popcount_scheduler #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           id;
    logic [7:0]   data;
    logic [3:0]   exp_count;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Waits (bounded) for any ack; lat is the number of negedges waited.
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (ack == '0 && lat < 10);
  endtask

  // Posts a lone request from an idle DUT and follows it to completion.
  task automatic run_vec(input int id, input logic [7:0] d, input logic [3:0] exp, input string tag);
    int lat;
    @(negedge clk);
    req = 4'(1) << id;
    req_data = '0;
    req_data[id*DW +: DW] = d;
    res_ready = 1'b1;
    wait_ack(lat);
    check({tag, "_ack"}, 32'(ack), 32'(4'(1) << id));
    check({tag, "_ack_latency"}, 32'(lat), 32'd1);
    req = '0;
    @(negedge clk);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_count"}, 32'(res_count), 32'(exp));
    check({tag, "_id"}, 32'(res_id), 32'(id));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, res_valid, busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_count"}, 32'(res_count), 32'd0);
    check({tag, "_id"}, 32'(res_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int exp_cnt_by_id [4] = '{1, 2, 4, 8};

  initial begin
    int lat;
    int n;
    int last_c;
    int last_id;

    vecs[0] = '{id: 1, data: 8'b1011_0010, exp_count: 4'd4};
    vecs[1] = '{id: 0, data: 8'h00,        exp_count: 4'd0};
    vecs[2] = '{id: 2, data: 8'hFF,        exp_count: 4'd8};
    vecs[3] = '{id: 3, data: 8'h80,        exp_count: 4'd1};
    vecs[4] = '{id: 0, data: 8'h7F,        exp_count: 4'd7};
    vecs[5] = '{id: 2, data: 8'hA5,        exp_count: 4'd4};
    vecs[6] = '{id: 3, data: 8'h01,        exp_count: 4'd1};
    vecs[7] = '{id: 1, data: 8'hFE,        exp_count: 4'd7};

    reset = 1'b1;
    req = '0;
    req_data = '0;
    res_ready = 1'b0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: single requests, including 0x00 and 0xFF extremes.
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].id, vecs[i].data, vecs[i].exp_count, $sformatf("vec%0d", i));
    end

    // Reset in RESP with backpressure; then pointer must restart at 0.
    @(negedge clk);
    req = 4'b0100;
    req_data = '0;
    req_data[2*DW +: DW] = 8'h3C;
    res_ready = 1'b0;
    wait_ack(lat);
    check("pre_rst_ack", 32'(ack), 32'h4);
    req = '0;
    @(negedge clk);
    check("pre_rst_valid", 32'(res_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("mid_resp_reset");
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1001;
    req_data = '0;
    res_ready = 1'b1;
    wait_ack(lat);
    check("rst_ptr_ack", 32'(ack), 32'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    run_vec(2, 8'h0F, 4'd4, "rst_lone2");

    // All requesters held: round-robin order 0,1,2,3,0 at one ack per 3 cycles.
    pulse_reset();
    @(negedge clk);
    req = 4'hF;
    req_data = {8'hFF, 8'h0F, 8'h03, 8'h01};
    res_ready = 1'b1;
    n = 0;
    last_c = 0;
    last_id = 0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        if (n < 5) begin
          check($sformatf("rr_ack%0d", n), 32'(ack), 32'(4'(1) << exp_order[n]));
          last_id = exp_order[n];
        end
        if (n > 0) check($sformatf("rr_spacing%0d", n), 32'(c - last_c), 32'd3);
        last_c = c;
        n++;
      end
      if (res_valid) begin
        check($sformatf("rr_id_c%0d", c), 32'(res_id), 32'(last_id));
        check($sformatf("rr_count_c%0d", c), 32'(res_count), 32'(exp_cnt_by_id[last_id]));
      end
    end
    check("rr_ack_total", 32'(n), 32'd5);
    req = '0;
    repeat (4) @(negedge clk);

    // Backpressure: result held five cycles, new request not served meanwhile.
    req = 4'b0010;
    req_data = '0;
    req_data[1*DW +: DW] = 8'hF0;
    res_ready = 1'b0;
    wait_ack(lat);
    check("bp_ack", 32'(ack), 32'h2);
    req = 4'b0100;
    req_data[2*DW +: DW] = 8'h11;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {16'd0, 4'(ack), 4'(res_count), 2'(res_id), res_valid, busy},
            {16'd0, 4'h0, 4'd4, 2'd1, 1'b1, 1'b1});
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_done", {30'd0, res_valid, busy}, 32'd0);
    @(negedge clk);
    check("bp_next_ack", 32'(ack), 32'h4);
    req = '0;
    repeat (3) @(negedge clk);

    // req[3] pulses only during COUNT and is never acknowledged.
    req = 4'b0010;
    req_data = '0;
    req_data[1*DW +: DW] = 8'h07;
    res_ready = 1'b1;
    wait_ack(lat);
    check("drop_ack", 32'(ack), 32'h2);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    check("drop_id", 32'(res_id), 32'd1);
    check("drop_count", 32'(res_count), 32'd3);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ack != '0) n++;
    end
    check("drop_never_acked", 32'(n), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
